// File: rtl/var_trace_fifo.sv
// Passive write-port tap: matches memory writes against a small watch table and
// queues tagged, timestamped records in a first-word-fall-through FIFO for readout.
module var_trace_fifo #(
   parameter int NADDRE = 64,
   parameter int NBDATA = 32,
   parameter int NWATCH = 4,
   parameter int FDEPTH = 16,
   parameter int TS_W   = 16,
   localparam int AW = $clog2(NADDRE),
   localparam int IW = (NWATCH > 1) ? $clog2(NWATCH) : 1,
   localparam int PW = $clog2(FDEPTH),
   localparam int CW = $clog2(FDEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [AW-1:0]     addr_w,
   input  logic [NBDATA-1:0] data_in,
   input  logic              cfg_we,
   input  logic [IW-1:0]     cfg_idx,
   input  logic              cfg_en,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [7:0]        cfg_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_tag,
   output logic [AW-1:0]     out_addr,
   output logic [TS_W-1:0]   out_ts,
   output logic [NBDATA-1:0] out_data,
   output logic [CW-1:0]     fifo_cnt,
   output logic [15:0]       ovf_cnt,
   output logic              overflow
);

   typedef struct packed {
      logic [7:0]        tag;
      logic [AW-1:0]     addr;
      logic [TS_W-1:0]   ts;
      logic [NBDATA-1:0] data;
   } rec_t;

   localparam logic [IW:0] NW_L = NWATCH[IW:0];

   logic              tab_en   [NWATCH];
   logic [AW-1:0]     tab_addr [NWATCH];
   logic [7:0]        tab_tag  [NWATCH];

   logic [TS_W-1:0]   ts;
   logic              cap_valid;
   rec_t              cap;
   rec_t              mem [FDEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;

   logic              hit;
   logic [7:0]        hit_tag;
   logic              idx_ok;
   logic              full;
   logic              pop;
   logic              do_push;
   logic              drop;
   rec_t              head;

   // Descending scan so the lowest matching index supplies the tag.
   always_comb begin
      hit     = 1'b0;
      hit_tag = '0;
      for (int i = NWATCH - 1; i >= 0; i--) begin
         if (wr && tab_en[i] && (tab_addr[i] == addr_w)) begin
            hit     = 1'b1;
            hit_tag = tab_tag[i];
         end
      end
   end

   // Handshake: a record transfers on every rising edge where out_valid && out_ready;
   // out_* hold the head record unchanged while out_valid=1 and out_ready=0.
   assign idx_ok    = ({1'b0, cfg_idx} < NW_L);
   assign full      = (cnt == CW'(FDEPTH));
   assign out_valid = (cnt != '0);
   assign pop       = out_valid && out_ready;
   assign do_push   = cap_valid && (!full || pop);
   assign drop      = cap_valid && full && !pop;
   assign head      = mem[rd_ptr];

   assign out_tag  = out_valid ? head.tag  : '0;
   assign out_addr = out_valid ? head.addr : '0;
   assign out_ts   = out_valid ? head.ts   : '0;
   assign out_data = out_valid ? head.data : '0;
   assign fifo_cnt = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts        <= '0;
         cap_valid <= 1'b0;
         cap       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         ovf_cnt   <= '0;
         overflow  <= 1'b0;
         for (int i = 0; i < NWATCH; i++) begin
            tab_en[i]   <= 1'b0;
            tab_addr[i] <= '0;
            tab_tag[i]  <= '0;
         end
      end else begin
         ts        <= ts + 1'b1;
         cap_valid <= hit;
         if (hit) begin
            cap <= '{tag: hit_tag, addr: addr_w, ts: ts, data: data_in};
         end
         // Match above already used the pre-write table contents.
         if (cfg_we && idx_ok) begin
            tab_en[cfg_idx]   <= cfg_en;
            tab_addr[cfg_idx] <= cfg_addr;
            tab_tag[cfg_idx]  <= cfg_tag;
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt + CW'(do_push) - CW'(pop);
         if (drop) begin
            overflow <= 1'b1;
            if (ovf_cnt != 16'hFFFF) begin
               ovf_cnt <= ovf_cnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem[wr_ptr] <= cap;
      end
   end

endmodule

// File: tb/tb_var_trace_fifo.sv
// Directed bench for var_trace_fifo: queue-based reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_var_trace_fifo;

   localparam int FDEPTH = 16;
   localparam int NWATCH = 4;

   typedef struct {
      logic [7:0]  tag;
      logic [5:0]  addr;
      logic [15:0] ts;
      logic [31:0] data;
   } rec_t;

   logic        clk;
   logic        rst;
   logic        wr;
   logic [5:0]  addr_w;
   logic [31:0] data_in;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic        cfg_en;
   logic [5:0]  cfg_addr;
   logic [7:0]  cfg_tag;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_tag;
   logic [5:0]  out_addr;
   logic [15:0] out_ts;
   logic [31:0] out_data;
   logic [4:0]  fifo_cnt;
   logic [15:0] ovf_cnt;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;

   var_trace_fifo dut (
      .clk(clk), .rst(rst), .wr(wr), .addr_w(addr_w), .data_in(data_in),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_addr(cfg_addr),
      .cfg_tag(cfg_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .out_addr(out_addr), .out_ts(out_ts), .out_data(out_data),
      .fifo_cnt(fifo_cnt), .ovf_cnt(ovf_cnt), .overflow(overflow)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   rec_t        mq[$];
   bit          m_pend_v;
   rec_t        m_pend;
   logic [15:0] m_ts;
   int          m_ovf;
   bit          m_overflow;
   bit          m_en   [NWATCH];
   logic [5:0]  m_addr [NWATCH];
   logic [7:0]  m_tag  [NWATCH];

   always @(posedge clk) begin
      bit pop;
      bit found;
      if (rst) begin
         mq.delete();
         m_pend_v   = 0;
         m_ts       = '0;
         m_ovf      = 0;
         m_overflow = 0;
         for (int i = 0; i < NWATCH; i++) begin
            m_en[i] = 0; m_addr[i] = '0; m_tag[i] = '0;
         end
      end else begin
         pop = (mq.size() > 0) && out_ready;
         if (pop) void'(mq.pop_front());
         if (m_pend_v) begin
            if (mq.size() < FDEPTH) mq.push_back(m_pend);
            else begin
               if (m_ovf < 65535) m_ovf++;
               m_overflow = 1;
            end
         end
         m_pend_v = 0;
         found = 0;
         if (wr) begin
            for (int i = 0; i < NWATCH; i++) begin
               if (!found && m_en[i] && m_addr[i] == addr_w) begin
                  found  = 1;
                  m_pend = '{tag: m_tag[i], addr: addr_w, ts: m_ts, data: data_in};
               end
            end
         end
         m_pend_v = found;
         if (cfg_we && int'(cfg_idx) < NWATCH) begin
            m_en[cfg_idx] = cfg_en; m_addr[cfg_idx] = cfg_addr; m_tag[cfg_idx] = cfg_tag;
         end
         m_ts = m_ts + 16'd1;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("status", {out_valid, fifo_cnt, ovf_cnt, overflow},
               {(mq.size() > 0), 5'(mq.size()), 16'(m_ovf), m_overflow});
         if (mq.size() > 0)
            check("head", {out_tag, out_addr, out_ts, out_data},
                  {mq[0].tag, mq[0].addr, mq[0].ts, mq[0].data});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [1:0] idx, input logic en, input logic [5:0] a,
                          input logic [7:0] tag);
      cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_addr = a; cfg_tag = tag;
   endtask

   task automatic set_wr(input logic w, input logic [5:0] a, input logic [31:0] d);
      wr = w; addr_w = a; data_in = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ts0;
      rst = 1'b1; wr = 1'b0; addr_w = '0; data_in = '0; cfg_we = 1'b0;
      cfg_idx = '0; cfg_en = 1'b0; cfg_addr = '0; cfg_tag = '0; out_ready = 1'b0;
      tick();
      cmp_en = 1;
      tick();
      rst = 1'b0;
      check("rst_valid", out_valid, 1'b0);
      check("rst_cnt", fifo_cnt, 5'd0);
      check("rst_ovf", {ovf_cnt, overflow}, 17'd0);

      // basic capture with 2-edge latency
      set_cfg(2'd0, 1'b1, 6'd23, 8'd23);
      tick();
      cfg_we = 1'b0;
      while (m_ts != 16'd10) tick();
      set_wr(1'b1, 6'd23, 32'h0000_0005);
      tick();
      set_wr(1'b0, '0, '0);
      check("t1_lat1", out_valid, 1'b0);
      tick();
      check("t1_valid", out_valid, 1'b1);
      check("t1_rec", {out_tag, out_addr, out_data, out_ts},
            {8'd23, 6'd23, 32'd5, 16'd10});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_pop", {out_valid, fifo_cnt}, 6'd0);

      // overlapping entries: lowest index wins, one record only
      set_cfg(2'd1, 1'b1, 6'd31, 8'h11);
      tick();
      set_cfg(2'd2, 1'b1, 6'd31, 8'h22);
      tick();
      cfg_we = 1'b0;
      set_wr(1'b1, 6'd31, 32'hABCD);
      tick();
      set_wr(1'b1, 6'd30, 32'h1234);
      tick();
      set_wr(1'b0, '0, '0);
      tick();
      check("t2_one", fifo_cnt, 5'd1);
      check("t2_tag", out_tag, 8'h11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t2_nomatch", fifo_cnt, 5'd0);

      // overflow: 20 writes into a 16-deep FIFO
      ts0 = m_ts;
      for (int i = 0; i < 20; i++) begin
         set_wr(1'b1, 6'd23, 32'(100 + i));
         tick();
      end
      set_wr(1'b0, '0, '0);
      tick();
      check("t3_cnt", fifo_cnt, 5'd16);
      check("t3_ovf", ovf_cnt, 16'd4);
      check("t3_flag", overflow, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t3_drain", {out_valid, out_data, out_ts}, {1'b1, 32'(100 + i), 16'(ts0 + 16'(i))});
         tick();
      end
      out_ready = 1'b0;
      check("t3_empty", {out_valid, fifo_cnt}, 6'd0);

      // full FIFO streaming with simultaneous push/pop across pointer wrap
      for (int i = 0; i < 16; i++) begin
         set_wr(1'b1, 6'd23, 32'(200 + i));
         tick();
      end
      set_wr(1'b0, '0, '0);
      tick();
      check("t4_full", fifo_cnt, 5'd16);
      set_wr(1'b1, 6'd23, 32'd300);
      tick();
      out_ready = 1'b1;
      for (int i = 1; i < 40; i++) begin
         set_wr(1'b1, 6'd23, 32'(300 + i));
         tick();
      end
      set_wr(1'b0, '0, '0);
      tick();
      out_ready = 1'b0;
      check("t4_cnt", fifo_cnt, 5'd16);
      check("t4_ovf", {ovf_cnt, overflow}, {16'd4, 1'b1});
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t4_drain", {out_valid, out_data}, {1'b1, 32'(324 + i)});
         tick();
      end
      out_ready = 1'b0;

      // config write in the same cycle as a write to that address
      set_cfg(2'd3, 1'b1, 6'd40, 8'h40);
      set_wr(1'b1, 6'd40, 32'h77);
      tick();
      cfg_we = 1'b0;
      set_wr(1'b0, '0, '0);
      tick();
      check("t5_none", {out_valid, fifo_cnt}, 6'd0);
      set_wr(1'b1, 6'd40, 32'h78);
      tick();
      set_wr(1'b0, '0, '0);
      tick();
      check("t5_rec", {out_valid, out_tag, out_data}, {1'b1, 8'h40, 32'h78});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // reset with stored records
      for (int i = 0; i < 8; i++) begin
         set_wr(1'b1, 6'd23, 32'(500 + i));
         tick();
      end
      set_wr(1'b0, '0, '0);
      tick();
      check("t6_pre", fifo_cnt, 5'd8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst", {out_valid, fifo_cnt, ovf_cnt, overflow}, 23'd0);
      set_wr(1'b1, 6'd23, 32'h99);
      tick();
      set_wr(1'b0, '0, '0);
      tick();
      check("t6_tab_off", {out_valid, fifo_cnt}, 6'd0);
      set_cfg(2'd0, 1'b1, 6'd23, 8'd23);
      tick();
      cfg_we = 1'b0;
      set_wr(1'b1, 6'd23, 32'h9A);
      tick();
      set_wr(1'b0, '0, '0);
      tick();
      check("t6_ts", {out_valid, out_ts, out_data}, {1'b1, 16'd3, 32'h9A});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/var_trace_fifo.md
Name: var_trace_fifo

Overview:
- Passive monitor on the data-memory write port (wr, addr_w, data_in) of a processor instance.
- Compares each write against a small programmable table of watched addresses.
- On a match, stores a tagged, timestamped record in an internal first-word-fall-through FIFO.
- Records drain through a valid/ready port to the simulation/debug readout; the memory write path is never stalled or modified.

Parameters:
- NADDRE, 64, memory depth; address width AW = $clog2(NADDRE)
- NBDATA, 32, data word width
- NWATCH, 4, number of watch-table entries; index width IW = max(1,$clog2(NWATCH))
- FDEPTH, 16, FIFO depth in records (power of two, >=2)
- TS_W, 16, timestamp width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr  in  1  memory write strobe (tap)
- addr_w  in  AW  memory write address (tap)
- data_in  in  NBDATA  memory write data (tap)
- cfg_we  in  1  watch-table write strobe
- cfg_idx  in  IW  entry index
- cfg_en  in  1  entry enable
- cfg_addr  in  AW  watched address
- cfg_tag  in  8  variable type tag stored in records
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_tag  out  8  record tag
- out_addr  out  AW  record address
- out_ts  out  TS_W  record timestamp
- out_data  out  NBDATA  record data
- fifo_cnt  out  $clog2(FDEPTH)+1  occupancy
- ovf_cnt  out  16  dropped-record count, saturating at 16'hFFFF
- overflow  out  1  sticky drop flag

Behaviour:
- Reset (rst=1 at edge): all outputs 0; FIFO empty; timestamp 0; capture stage invalid; all table entries disabled (en=0, addr=0, tag=0). Reset mid-operation discards in-flight and stored records without emitting them.
- Timestamp: free-running TS_W counter, +1 every cycle out of reset; wraps at all-ones back to 0.
- Config: when cfg_we=1, entry cfg_idx is loaded at the edge. Match logic in that same cycle uses the pre-write table contents. cfg_idx >= NWATCH is ignored.
- Stage 1 (capture):
  - At edge k, if wr=1 and some enabled entry has addr == addr_w, register {tag, addr_w, data_in, ts_k}.
  - If several entries match, the lowest index supplies the tag; exactly one record is produced.
  - Non-matching writes are ignored.
- Stage 2 (push): the captured record is pushed at edge k+1. out_valid rises after edge k+1 if the FIFO was empty. Fixed latency: 2 edges from write to visible record.
- Throughput: one record per cycle; back-to-back matching writes all captured.
- Output handshake:
  - out_* holds the head record while out_valid=1.
  - Pop occurs at an edge with out_valid && out_ready.
  - Head data is stable while out_ready=0.
  - out_ready is ignored when the FIFO is empty.
- Full handling:
  - Push while full with no pop in the same cycle: record dropped, ovf_cnt +1 (saturating), overflow set to 1.
  - overflow clears only on rst.
  - Push and pop in the same cycle while full: both succeed, no drop, count unchanged.
- Empty with push, no pop: count becomes 1.
- fifo_cnt is registered, range 0..FDEPTH.
- Pointer wrap: read/write pointers wrap modulo FDEPTH; full/empty are derived from fifo_cnt, never pointer equality alone.

Test Plan:
- Reset, then write entry0 {en=1, addr=23, tag=8'd23}; wr addr 23 data 32'h0000_0005 at ts=10 -> after 2 edges out_valid=1, out_tag=23, out_addr=23, out_data=5, out_ts=10; pop with out_ready=1 -> out_valid=0, fifo_cnt=0.
- Entries 1 and 2 both watch addr 31 (tags 8'h11, 8'h22); write addr 31 once -> exactly one record with tag 8'h11. Write addr 30 -> no record.
- out_ready=0; 20 consecutive matching writes with FDEPTH=16 -> fifo_cnt=16, ovf_cnt=4, overflow=1. Then drain -> 16 records in write order, timestamps strictly consecutive, the last 4 writes absent.
- FIFO full, out_ready=1, matching write every cycle for 40 cycles -> no drops, ovf_cnt unchanged, fifo_cnt stays 16, records in order across pointer wrap.
- cfg_we enabling addr 40 in the same cycle as a wr to addr 40 -> no record; next wr to 40 -> record produced.
- 8 records stored, rst pulsed one cycle -> next cycle out_valid=0, fifo_cnt=0, ovf_cnt=0, overflow=0, table disabled (wr to 23 produces nothing), timestamp restarts at 0.
